// File: rtl/riscv_defines.sv
// Shared constants and types for the instruction-memory responder.
package riscv_defines;

  localparam logic [31:0] MEM_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    WAIT     = 1'b0,
    GRANT_OK = 1'b1
  } gnt_state_e;

  typedef struct packed {
    logic        valid;
    logic [29:0] waddr;
    logic        oor;
  } imem_pipe_entry_t;

endpackage

// File: rtl/riscv_imem_array.sv
// Word-organised instruction memory: one backdoor write port, one async read port.
module riscv_imem_array
  import riscv_defines::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [2**ADDR_WIDTH];

  // Backdoor write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/riscv_instr_mem_responder.sv
// Instruction-fetch responder: grant-delay FSM, outstanding limit and a fixed
// latency pipe in front of a word-organised memory.
module riscv_instr_mem_responder
  import riscv_defines::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter int GNT_DELAY       = 0,
  parameter int RVALID_LATENCY  = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic [31:0]           instr_rdata_o,
  output logic                  instr_rvalid_o,
  input  logic                  stall_i,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [31:0]           load_wdata_i,
  output logic                  oor_o
);

  localparam int CNT_W = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  gnt_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [OUT_W-1:0] out_cnt_r;
  logic             rvalid_r, oor_r;
  logic [31:0]      rdata_r, rd_word_s;
  logic             addr_oor_s, delay_done_s, room_s, gnt_s;
  imem_pipe_entry_t new_entry_s, last_s;
  logic             unused_s;

  assign addr_oor_s   = |instr_addr_i[31:ADDR_WIDTH+2];
  assign delay_done_s = (state_r == GRANT_OK) || (cnt_r == CNT_W'(GNT_DELAY));
  // A retiring response frees its slot in the same cycle
  assign room_s       = (out_cnt_r < OUT_W'(MAX_OUTSTANDING)) || rvalid_r;
  assign gnt_s        = ~rst & instr_req_i & delay_done_s & ~stall_i & room_s;

  assign new_entry_s = '{valid: gnt_s,
                         waddr: 30'(instr_addr_i[ADDR_WIDTH+1:2]),
                         oor:   addr_oor_s};

  // Grant FSM next state: count held-request cycles up to GNT_DELAY
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      WAIT: begin
        if (!instr_req_i || gnt_s) begin
          cnt_s = '0;
        end else if (delay_done_s) begin
          state_s = GRANT_OK;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      GRANT_OK: begin
        if (!instr_req_i || gnt_s) begin
          state_s = WAIT;
          cnt_s   = '0;
        end else begin
          state_s = GRANT_OK;
        end
      end
      default: begin
        state_s = WAIT;
        cnt_s   = '0;
      end
    endcase
  end

  // Grant FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  generate
    if (RVALID_LATENCY == 1) begin : g_direct
      assign last_s = new_entry_s;
    end else begin : g_pipe
      imem_pipe_entry_t pipe_r [RVALID_LATENCY-1];

      // Shift granted requests toward the read stage; reset drops them
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RVALID_LATENCY - 1; i++) begin
            pipe_r[i] <= '0;
          end
        end else begin
          pipe_r[0] <= new_entry_s;
          for (int i = 1; i < RVALID_LATENCY - 1; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign last_s = pipe_r[RVALID_LATENCY-2];
    end
  endgenerate

  riscv_imem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (load_we_i),
    .waddr(load_addr_i),
    .wdata(load_wdata_i),
    .raddr(last_s.waddr[ADDR_WIDTH-1:0]),
    .rdata(rd_word_s)
  );

  // Response register and sticky out-of-range flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      oor_r    <= 1'b0;
    end else begin
      rvalid_r <= last_s.valid;
      if (last_s.valid) begin
        rdata_r <= last_s.oor ? MEM_NOP : rd_word_s;
      end else begin
        rdata_r <= rdata_r;
      end
      oor_r <= oor_r | (gnt_s & addr_oor_s);
    end
  end

  // Outstanding count: +1 per grant, -1 per delivered response
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_r <= '0;
    end else begin
      case ({gnt_s, rvalid_r})
        2'b10:   out_cnt_r <= out_cnt_r + OUT_W'(1);
        2'b01:   out_cnt_r <= out_cnt_r - OUT_W'(1);
        default: out_cnt_r <= out_cnt_r;
      endcase
    end
  end

  assign unused_s       = ^{instr_addr_i[1:0], last_s.waddr[29:ADDR_WIDTH]};
  assign instr_gnt_o    = gnt_s;
  assign instr_rvalid_o = rvalid_r;
  assign instr_rdata_o  = rdata_r;
  assign oor_o          = oor_r;

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Bench for riscv_instr_mem_responder: three configurations against a
// queue-based scoreboard, plus table-driven and hand-written corner sequences.
module tb_riscv_instr_mem_responder;

  localparam int GD_P  [3] = '{0, 2, 0};
  localparam int LAT_P [3] = '{1, 4, 3};
  localparam int MX_P  [3] = '{2, 2, 1};

  localparam logic [31:0] WA = 32'hA000_0001, WB = 32'hB000_0002;
  localparam logic [31:0] WC = 32'hC000_0003, WD = 32'hD000_0004;
  localparam logic [31:0] WE = 32'hE000_0005, W200 = 32'h2222_0200;
  localparam logic [31:0] W300 = 32'h3333_0300;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, stall, gnt, rvalid, oor;
  logic [31:0] addr [3];
  logic [31:0] rdata [3];
  logic        we;
  logic [11:0] laddr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  riscv_instr_mem_responder #(.ADDR_WIDTH(12), .GNT_DELAY(0), .RVALID_LATENCY(1), .MAX_OUTSTANDING(2)) u0 (
    .clk(clk), .rst(rst), .instr_req_i(req[0]), .instr_addr_i(addr[0]), .instr_gnt_o(gnt[0]),
    .instr_rdata_o(rdata[0]), .instr_rvalid_o(rvalid[0]), .stall_i(stall[0]), .load_we_i(we),
    .load_addr_i(laddr), .load_wdata_i(wdata), .oor_o(oor[0]));
  riscv_instr_mem_responder #(.ADDR_WIDTH(12), .GNT_DELAY(2), .RVALID_LATENCY(4), .MAX_OUTSTANDING(2)) u1 (
    .clk(clk), .rst(rst), .instr_req_i(req[1]), .instr_addr_i(addr[1]), .instr_gnt_o(gnt[1]),
    .instr_rdata_o(rdata[1]), .instr_rvalid_o(rvalid[1]), .stall_i(stall[1]), .load_we_i(we),
    .load_addr_i(laddr), .load_wdata_i(wdata), .oor_o(oor[1]));
  riscv_instr_mem_responder #(.ADDR_WIDTH(12), .GNT_DELAY(0), .RVALID_LATENCY(3), .MAX_OUTSTANDING(1)) u2 (
    .clk(clk), .rst(rst), .instr_req_i(req[2]), .instr_addr_i(addr[2]), .instr_gnt_o(gnt[2]),
    .instr_rdata_o(rdata[2]), .instr_rvalid_o(rvalid[2]), .stall_i(stall[2]), .load_we_i(we),
    .load_addr_i(laddr), .load_wdata_i(wdata), .oor_o(oor[2]));

  int          checks, errors, cyc;
  int          held [3];
  int          qn [3];
  int          qh [3];
  int          q_due [3][16];
  logic [31:0] q_data [3][16];
  logic [11:0] q_wa [3][16];
  logic        q_oor [3][16];
  logic [31:0] last_rd [3];
  logic        m_oor [3];
  logic [31:0] mem_m [4096];
  logic [2:0]  s_gnt, s_rv, s_oor;
  logic [31:0] s_rd [3];

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        oor;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard: responses due LAT cycles after grant, data read one cycle before
  task automatic model_step(input int k);
    logic        ret, egnt;
    logic [31:0] exp_rd;
    int          t;
    ret    = (qn[k] > 0) && (q_due[k][qh[k]] == cyc);
    exp_rd = ret ? q_data[k][qh[k]] : last_rd[k];
    egnt   = !rst && req[k] && (held[k] >= GD_P[k]) && !stall[k] && ((qn[k] < MX_P[k]) || ret);
    chk($sformatf("rvalid%0d", k), 32'(s_rv[k]), 32'(ret));
    chk($sformatf("rdata%0d", k), s_rd[k], exp_rd);
    chk($sformatf("oor%0d", k), 32'(s_oor[k]), 32'(m_oor[k]));
    chk($sformatf("gnt%0d", k), 32'(s_gnt[k]), 32'(egnt));
    if (rst) begin
      qn[k] = 0; held[k] = 0; m_oor[k] = 1'b0; last_rd[k] = 32'h0;
    end else begin
      if (ret) begin
        last_rd[k] = exp_rd;
        qh[k] = (qh[k] + 1) % 16;
        qn[k]--;
      end
      if (egnt) begin
        t = (qh[k] + qn[k]) % 16;
        q_due[k][t] = cyc + LAT_P[k];
        q_wa[k][t]  = addr[k][13:2];
        q_oor[k][t] = |addr[k][31:14];
        m_oor[k]    = m_oor[k] | q_oor[k][t];
        qn[k]++;
        held[k] = 0;
      end else if (req[k]) begin
        held[k]++;
      end else begin
        held[k] = 0;
      end
      for (int i = 0; i < qn[k]; i++) begin
        t = (qh[k] + i) % 16;
        if (q_due[k][t] == cyc + 1) q_data[k][t] = q_oor[k][t] ? 32'h0000_0013 : mem_m[q_wa[k][t]];
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    s_gnt = gnt; s_rv = rvalid; s_oor = oor;
    for (int k = 0; k < 3; k++) s_rd[k] = rdata[k];
    for (int k = 0; k < 3; k++) model_step(k);
    if (we) mem_m[laddr] = wdata;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [11:0] a, input logic [31:0] d);
    we = 1'b1; laddr = a; wdata = d;
    cycle();
    we = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    for (int k = 0; k < 3; k++) begin
      held[k] = 0; qn[k] = 0; qh[k] = 0; last_rd[k] = 32'h0; m_oor[k] = 1'b0;
      addr[k] = 32'h0;
    end
    rst = 1'b1; req = 3'b000; stall = 3'b000; we = 1'b0; laddr = 12'h0; wdata = 32'h0;

    tbl[0]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0104, 1'b0, 1'b1, 1'b1, WA,     1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0108, 1'b0, 1'b1, 1'b1, WB,     1'b0};
    tbl[3]  = '{1'b1, 32'h0000_010C, 1'b0, 1'b1, 1'b1, WC,     1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, WD,     1'b0};
    tbl[5]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, WD,     1'b0};
    tbl[6]  = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, WD,     1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0104, 1'b0, 1'b1, 1'b0, WD,     1'b0};
    tbl[8]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, WB,     1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h13, 1'b1};
    tbl[10] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h13, 1'b1};

    // Preload the image while reset is held
    for (int w = 0; w < 16; w++) write_word(12'(w), $urandom);
    write_word(12'h040, WA); write_word(12'h041, WB);
    write_word(12'h042, WC); write_word(12'h043, WD);
    write_word(12'h080, W200); write_word(12'h0C0, W300);
    req = 3'b111;
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk("rst_gnt", 32'(s_gnt[k]), 32'h0);
      chk("rst_rvalid", 32'(s_rv[k]), 32'h0);
      chk("rst_rdata", s_rd[k], 32'h0);
      chk("rst_oor", 32'(s_oor[k]), 32'h0);
    end
    rst = 1'b0; req = 3'b000;

    for (int i = 0; i < 11; i++) begin
      req[0] = tbl[i].req; addr[0] = tbl[i].addr; stall[0] = tbl[i].stall;
      cycle();
      chk($sformatf("tbl%0d_gnt", i), 32'(s_gnt[0]), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_rv", i), 32'(s_rv[0]), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_rd", i), s_rd[0], tbl[i].rd);
      chk($sformatf("tbl%0d_oor", i), 32'(s_oor[0]), 32'(tbl[i].oor));
    end
    stall[0] = 1'b0;

    // Backdoor write in the read cycle returns the old word
    req[0] = 1'b1; addr[0] = 32'h10C; we = 1'b1; laddr = 12'h043; wdata = WE;
    cycle();
    chk("bd_gnt", 32'(s_gnt[0]), 32'h1);
    we = 1'b0;
    cycle();
    chk("bd_old", s_rd[0], WD);
    req[0] = 1'b0;
    cycle();
    chk("bd_new_rv", 32'(s_rv[0]), 32'h1);
    chk("bd_new", s_rd[0], WE);

    // Grant delay with address redirect while waiting
    for (int c = 0; c < 7; c++) begin
      req[1] = (c < 3); addr[1] = (c == 0) ? 32'h200 : 32'h300;
      cycle();
      chk("dly_gnt", 32'(s_gnt[1]), 32'(c == 2));
      chk("dly_rv", 32'(s_rv[1]), 32'(c == 6));
      if (c == 6) chk("dly_data", s_rd[1], W300);
    end

    // Abandoned requests still get their responses, in order
    for (int c = 0; c < 12; c++) begin
      req[1] = (c < 6); addr[1] = (c < 3) ? 32'h100 : 32'h104;
      cycle();
      chk("abt_gnt", 32'(s_gnt[1]), 32'((c == 2) || (c == 5)));
      chk("abt_rv", 32'(s_rv[1]), 32'((c == 6) || (c == 9)));
      if (c == 6) chk("abt_d0", s_rd[1], WA);
      if (c == 9) chk("abt_d1", s_rd[1], WB);
    end

    // Outstanding limit of one with latency three
    for (int c = 0; c < 13; c++) begin
      req[2] = (c < 10); addr[2] = 32'h108;
      cycle();
      chk("lim_gnt", 32'(s_gnt[2]), 32'((c < 10) && (c % 3 == 0)));
      chk("lim_rv", 32'(s_rv[2]), 32'((c >= 3) && (c % 3 == 0)));
      if (s_rv[2]) chk("lim_data", s_rd[2], WC);
    end

    // Randomized traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        req[k]   = ($urandom_range(3, 0) != 0);
        stall[k] = ($urandom_range(4, 0) == 0);
        if ($urandom_range(7, 0) == 0) addr[k] = {1'b1, 25'($urandom), 4'($urandom_range(15, 0)), 2'b00};
        else addr[k] = {26'd0, 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0))};
      end
      we = ($urandom_range(3, 0) == 0); laddr = {8'd0, 4'($urandom_range(15, 0))}; wdata = $urandom;
      cycle();
    end
    req = 3'b000; stall = 3'b000; we = 1'b0;
    for (int n = 0; n < 8; n++) cycle();

    // Reset with requests in flight; post-reset fetch sees preserved array
    for (int c = 0; c < 15; c++) begin
      req[1] = (c < 6); addr[1] = 32'h100;
      rst = (c == 6);
      req[2] = (c == 7); addr[2] = 32'h100;
      cycle();
      if (c == 0) chk("oor_sticky", 32'(s_oor[0]), 32'h1);
      if (c == 7) chk("oor_cleared", 32'(s_oor[0]), 32'h0);
      if (c >= 7) chk("rst_drop_rv", 32'(s_rv[1]), 32'h0);
      if (c >= 7) chk("post_gnt", 32'(s_gnt[2]), 32'(c == 7));
      if (c == 10) chk("post_rv", 32'(s_rv[2]), 32'h1);
      if (c == 10) chk("post_data", s_rd[2], WA);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
